// File: rtl/color_fader_if.sv
// Target-colour handshake between a producer (master) and color_fader (slave).
// A target transfers on every rising clock edge where tgt_valid_i and tgt_ready_o are both high.
interface color_fader_if;
  logic        tgt_valid_i;
  logic        tgt_ready_o;
  logic [23:0] tgt_color_i;

  modport master (
    output tgt_valid_i,
    output tgt_color_i,
    input  tgt_ready_o
  );

  modport slave (
    input  tgt_valid_i,
    input  tgt_color_i,
    output tgt_ready_o
  );
endinterface

// File: rtl/color_fader.sv
// Steps an RGB colour one LSB per channel toward queued targets, once every STEP_DIV mixer ticks.
// Define COLOR_FADER_QUEUE_EN for a 4-entry target FIFO; otherwise a single holding register is used.
module color_fader #(
  parameter int unsigned STEP_DIV = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  color_fader_if.slave tgt,
  input  logic         tick_i,
  output logic [23:0]  color_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [1:0]   state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FADE = 2'd2
  } state_e;

  localparam logic [7:0] DIV_LAST = 8'(STEP_DIV - 1);

  state_e      state_q, state_d;
  logic [23:0] color_q, color_d;
  logic [23:0] tgt_q, tgt_d;
  logic [7:0]  div_q, div_d;
  logic        done_q, done_d;

  logic        push, pop;
  logic        q_empty, q_full;
  logic [23:0] q_head;
  logic        step_en;
  logic [23:0] step_color;

  assign push            = tgt.tgt_valid_i && tgt.tgt_ready_o;
  assign tgt.tgt_ready_o = !q_full;

`ifdef COLOR_FADER_QUEUE_EN
  logic [23:0] mem_q [4];
  logic [1:0]  wr_q, rd_q;
  logic [2:0]  cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= 2'd0;
      rd_q  <= 2'd0;
      cnt_q <= 3'd0;
    end else begin
      if (push) wr_q <= wr_q + 2'd1;
      if (pop)  rd_q <= rd_q + 2'd1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= tgt.tgt_color_i;
  end

  assign q_full  = (cnt_q == 3'd4);
  assign q_empty = (cnt_q == 3'd0);
  assign q_head  = mem_q[rd_q];
`else
  logic        hold_vld_q;
  logic [23:0] hold_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_vld_q <= 1'b0;
      hold_q     <= 24'h000000;
    end else if (push) begin
      hold_vld_q <= 1'b1;
      hold_q     <= tgt.tgt_color_i;
    end else if (pop) begin
      hold_vld_q <= 1'b0;
    end
  end

  assign q_full  = hold_vld_q;
  assign q_empty = !hold_vld_q;
  assign q_head  = hold_q;
`endif

  function automatic logic [7:0] chan_step(input logic [7:0] cur, input logic [7:0] goal);
    if (cur < goal)      return cur + 8'd1;
    else if (cur > goal) return cur - 8'd1;
    else                 return cur;
  endfunction

  assign step_color = {chan_step(color_q[23:16], tgt_q[23:16]),
                       chan_step(color_q[15:8],  tgt_q[15:8]),
                       chan_step(color_q[7:0],   tgt_q[7:0])};
  assign step_en    = (state_q == S_FADE) && tick_i && (div_q == DIV_LAST);

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!q_empty) state_d = S_LOAD;
      S_LOAD:  state_d = (tgt_q == color_q) ? S_IDLE : S_FADE;
      S_FADE:  if (step_en && (step_color == tgt_q)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs. The pop happens on the edge entering LOAD, so tgt_q is valid throughout LOAD.
  always_comb begin
    busy_o = (state_q == S_LOAD) || (state_q == S_FADE);
    pop    = (state_q == S_IDLE) && !q_empty;
    done_d = ((state_q == S_LOAD) && (tgt_q == color_q)) ||
             (step_en && (step_color == tgt_q));
  end

  always_comb begin
    div_d = div_q;
    if (state_q != S_FADE) div_d = 8'd0;
    else if (tick_i)       div_d = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
  end

  assign color_d = step_en ? step_color : color_q;
  assign tgt_d   = pop ? q_head : tgt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      color_q <= 24'h000000;
      tgt_q   <= 24'h000000;
      div_q   <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      color_q <= color_d;
      tgt_q   <= tgt_d;
      div_q   <= div_d;
      done_q  <= done_d;
    end
  end

  assign color_o = color_q;
  assign done_o  = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_color_fader.sv
// Bench for color_fader: two instances (STEP_DIV 1 and 4) checked by a scoreboard against a tick-counting fade model.
module tb_color_fader;

`ifdef COLOR_FADER_QUEUE_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  valid, tick;
  logic [23:0] tcol [2];
  logic [1:0]  rdy, busy, done;
  logic [23:0] col [2];
  logic [1:0]  st [2];

  // scoreboard / model state
  logic [23:0] exp_q [2][$];
  logic [23:0] m_col [2];
  int          tcnt [2];
  int          pend [2];
  logic [1:0]  cap_push, cap_tick;
  logic [23:0] cap_col [2];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic        rdy_mode;
  int          rdy_inst;
  logic        tmo;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    color_fader_if u_if ();
    assign u_if.tgt_valid_i = valid[g];
    assign u_if.tgt_color_i = tcol[g];
    assign rdy[g]           = u_if.tgt_ready_o;

    color_fader #(.STEP_DIV((g == 0) ? 1 : 4)) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .tgt    (u_if.slave),
      .tick_i (tick[g]),
      .color_o(col[g]),
      .busy_o (busy[g]),
      .done_o (done[g]),
      .state_o(st[g])
    );
  end

  function automatic int sd(input int g);
    return (g == 0) ? 1 : 4;
  endfunction

  function automatic logic [23:0] fade_step(input logic [23:0] c, input logic [23:0] t);
    logic [23:0] r;
    int cc, tt;
    r = c;
    for (int k = 0; k < 3; k++) begin
      cc = int'(c[8*k +: 8]);
      tt = int'(t[8*k +: 8]);
      if (cc < tt)      cc = cc + 1;
      else if (cc > tt) cc = cc - 1;
      r[8*k +: 8] = 8'(cc);
    end
    return r;
  endfunction

  task automatic chk(input string name, input int g, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] @%0t: got %h expected %h", name, g, $time, act, exp);
    end
  endtask

  // Capture what each DUT saw on the rising edge.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      cap_push[g] = rst_n && valid[g] && rdy[g];
      cap_tick[g] = rst_n && tick[g];
      cap_col[g]  = tcol[g];
    end
  end

  // Monitor: advance the model for the edge just passed, then compare.
  always @(negedge clk) begin
    logic step_done;
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        exp_q[g].delete();
        m_col[g] = 24'h0;
        tcnt[g]  = 0;
        pend[g]  = 0;
        chk("rst_color", g, col[g], 24'h0);
        chk("rst_busy",  g, {23'd0, busy[g]}, 24'd0);
        chk("rst_done",  g, {23'd0, done[g]}, 24'd0);
        chk("rst_ready", g, {23'd0, rdy[g]}, 24'd1);
      end else begin
        step_done = 1'b0;
        if (cap_tick[g] && exp_q[g].size() > 0 && m_col[g] != exp_q[g][0]) begin
          tcnt[g]++;
          if (tcnt[g] == sd(g)) begin
            tcnt[g]   = 0;
            m_col[g]  = fade_step(m_col[g], exp_q[g][0]);
            step_done = (m_col[g] == exp_q[g][0]);
          end
        end
        if (cap_push[g]) begin
          exp_q[g].push_back(cap_col[g]);
          pend[g]++;
        end
        chk("color", g, col[g], m_col[g]);
        if (step_done) chk("done_on_arrival", g, {23'd0, done[g]}, 24'd1);
        if (done[g]) begin
          if (exp_q[g].size() == 0) begin
            chk("done_unexpected", g, {23'd0, done[g]}, 24'd0);
          end else begin
            chk("done_target", g, col[g], exp_q[g][0]);
            void'(exp_q[g].pop_front());
            pend[g]--;
            tcnt[g] = 0;
          end
        end
        if (rdy_mode && g == rdy_inst)
          chk("ready", g, {23'd0, rdy[g]}, {23'd0, (exp_q[g].size() - 1) < DEPTH});
      end
    end
    chk("wait_bound", 0, {23'd0, tmo}, 24'd0);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic tick_ok(input int i);
    return (st[i] == 2'd2) || (st[i] == 2'd0 && pend[i] == 0);
  endfunction

  task automatic push(input int i, input logic [23:0] c, input logic allow_tick);
    int n;
    n = 0;
    valid[i] = 1'b1;
    tcol[i]  = c;
    while (!rdy[i] && n < 6000) begin
      tick[i] = allow_tick && tick_ok(i) && ($urandom_range(0, 1) == 1);
      step();
      tick[i] = 1'b0;
      n++;
    end
    if (!rdy[i]) tmo = 1'b1;
    step();
    valid[i] = 1'b0;
  endtask

  task automatic tick_n(input int i, input int cnt);
    int k, n;
    k = 0;
    n = 0;
    while (k < cnt && n < 2000) begin
      if (tick_ok(i)) begin
        tick[i] = 1'b1;
        step();
        tick[i] = 1'b0;
        k++;
      end
      step();
      n++;
    end
    if (k < cnt) tmo = 1'b1;
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while (pend[i] != 0 && n < 6000) begin
      tick[i] = tick_ok(i) && ($urandom_range(0, 3) != 0);
      step();
      tick[i] = 1'b0;
      n++;
    end
    if (pend[i] != 0) tmo = 1'b1;
  endtask

  task automatic wait_fade(input int i);
    int n;
    n = 0;
    while (st[i] != 2'd2 && n < 100) begin
      step();
      n++;
    end
    if (st[i] != 2'd2) tmo = 1'b1;
  endtask

  initial begin
    logic [23:0] burst [5];
    int          ri;
    logic [23:0] rc;
    valid    = 2'b00;
    tick     = 2'b00;
    tcol[0]  = 24'h0;
    tcol[1]  = 24'h0;
    rdy_mode = 1'b0;
    rdy_inst = 0;
    tmo      = 1'b0;
    rst_n    = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // ticks with nothing queued must be ignored
    tick = 2'b11;
    step();
    step();
    tick = 2'b00;
    step();

    push(0, 24'h030000, 1'b0);
    tick_n(0, 3);
    drain(0);

    push(0, 24'h050505, 1'b0);
    drain(0);
    push(0, 24'h030705, 1'b0);
    tick_n(0, 2);
    drain(0);

    push(1, 24'h000001, 1'b0);
    tick_n(1, 4);
    drain(1);

    // target equal to the current colour
    push(0, 24'h030705, 1'b0);
    drain(0);

    // back-to-back pushes while a long fade is stalled
    push(0, 24'h0a0a0a, 1'b0);
    wait_fade(0);
    rdy_inst = 0;
    rdy_mode = 1'b1;
    burst = '{24'h090a0b, 24'h0b0b0b, 24'h000000, 24'h010203, 24'h050505};
    for (int k = 0; k < 5; k++) begin
      if (k == DEPTH) begin
        valid[0] = 1'b1;
        tcol[0]  = burst[k];
        repeat (3) step();
        rdy_mode = 1'b0;
      end
      push(0, burst[k], k >= DEPTH);
    end
    rdy_mode = 1'b0;
    drain(0);

    // reset in the middle of a fade
    push(0, 24'h404040, 1'b0);
    push(1, 24'h404040, 1'b0);
    wait_fade(0);
    wait_fade(1);
    tick_n(0, 5);
    tick_n(1, 6);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    push(1, 24'h000300, 1'b0);
    drain(1);

    for (int r = 0; r < 14; r++) begin
      ri = int'($urandom_range(0, 1));
      rc = {8'($urandom_range(0, 9)), 8'($urandom_range(0, 9)), 8'($urandom_range(0, 9))};
      push(ri, rc, 1'b1);
      if ($urandom_range(0, 2) == 0) drain(ri);
    end
    drain(0);
    drain(1);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
